// File: rtl/rv_pkg.sv
// Shared RV execute-stage definitions: datapath widths, ALU select codes,
// operand-source encodings and the operand-stage state type.
package rv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned SEL_W  = 4;

  localparam logic [SEL_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [SEL_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [SEL_W-1:0] ALU_SLL  = 4'b0010;
  localparam logic [SEL_W-1:0] ALU_SLT  = 4'b0011;
  localparam logic [SEL_W-1:0] ALU_SLTU = 4'b0100;
  localparam logic [SEL_W-1:0] ALU_XOR  = 4'b0101;
  localparam logic [SEL_W-1:0] ALU_SRL  = 4'b0110;
  localparam logic [SEL_W-1:0] ALU_SRA  = 4'b0111;
  localparam logic [SEL_W-1:0] ALU_OR   = 4'b1000;
  localparam logic [SEL_W-1:0] ALU_AND  = 4'b1001;

  typedef enum logic {
    SRC_RS1 = 1'b0,
    SRC_PC  = 1'b1
  } opA_src_t;

  typedef enum logic {
    SRC_RS2 = 1'b0,
    SRC_IMM = 1'b1
  } opB_src_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_t;

endpackage

// File: rtl/alu_operand_stage_fwd_mux.sv
// Combinational operand forwarding for one source register: EX/MEM wins over
// MEM/WB, and x0 always reads the register-file value.
module fwd_mux
  import rv_pkg::*;
#(
  parameter int unsigned XLEN   = rv_pkg::XLEN,
  parameter int unsigned REG_AW = rv_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] rsAddr,
  input  logic [XLEN-1:0]   rsData,
  input  logic              exMemRegWrite,
  input  logic [REG_AW-1:0] exMemRd,
  input  logic [XLEN-1:0]   exMemResult,
  input  logic              memWbRegWrite,
  input  logic [REG_AW-1:0] memWbRd,
  input  logic [XLEN-1:0]   memWbResult,
  output logic [XLEN-1:0]   fwdData
);

  logic rsNonZero;
  logic exMatch;
  logic wbMatch;

  always_comb begin
    rsNonZero = (rsAddr != '0);
    exMatch   = exMemRegWrite && (exMemRd == rsAddr) && rsNonZero;
    wbMatch   = memWbRegWrite && (memWbRd == rsAddr) && rsNonZero;
    fwdData   = rsData;
    if (exMatch) begin
      fwdData = exMemResult;
    end else if (wbMatch) begin
      fwdData = memWbResult;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Execute-entry pipeline register feeding the ALU: resolves forwarding and
// operand selection at capture, holds under stall, and drops on flush.
module alu_operand_stage
  import rv_pkg::*;
#(
  parameter int unsigned XLEN   = rv_pkg::XLEN,
  parameter int unsigned SEL_W  = rv_pkg::SEL_W,
  parameter int unsigned REG_AW = rv_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inValid,
  output logic              inReady,
  input  logic [XLEN-1:0]   rs1Data,
  input  logic [XLEN-1:0]   rs2Data,
  input  logic [REG_AW-1:0] rs1Addr,
  input  logic [REG_AW-1:0] rs2Addr,
  input  logic [XLEN-1:0]   pcIn,
  input  logic [XLEN-1:0]   immIn,
  input  logic              opASrc,
  input  logic              opBSrc,
  input  logic [SEL_W-1:0]  aluSelIn,
  input  logic [REG_AW-1:0] rdAddrIn,
  input  logic              regWriteIn,
  input  logic              exMemRegWrite,
  input  logic [REG_AW-1:0] exMemRd,
  input  logic [XLEN-1:0]   exMemResult,
  input  logic              memWbRegWrite,
  input  logic [REG_AW-1:0] memWbRd,
  input  logic [XLEN-1:0]   memWbResult,
  input  logic              flush,
  input  logic              outReady,
  output logic              outValid,
  output logic [XLEN-1:0]   opA,
  output logic [XLEN-1:0]   opB,
  output logic [SEL_W-1:0]  aluOutSel,
  output logic [XLEN-1:0]   storeData,
  output logic [REG_AW-1:0] rdAddrOut,
  output logic              regWriteOut
);

  stage_state_t    state;
  opA_src_t        aSrc;
  opB_src_t        bSrc;
  logic [XLEN-1:0] fwdRs1;
  logic [XLEN-1:0] fwdRs2;
  logic [XLEN-1:0] nextA;
  logic [XLEN-1:0] nextB;
  logic            capture;
  logic            transfer;

  fwd_mux #(
    .XLEN   (XLEN),
    .REG_AW (REG_AW)
  ) u_fwdRs1 (
    .rsAddr        (rs1Addr),
    .rsData        (rs1Data),
    .exMemRegWrite (exMemRegWrite),
    .exMemRd       (exMemRd),
    .exMemResult   (exMemResult),
    .memWbRegWrite (memWbRegWrite),
    .memWbRd       (memWbRd),
    .memWbResult   (memWbResult),
    .fwdData       (fwdRs1)
  );

  fwd_mux #(
    .XLEN   (XLEN),
    .REG_AW (REG_AW)
  ) u_fwdRs2 (
    .rsAddr        (rs2Addr),
    .rsData        (rs2Data),
    .exMemRegWrite (exMemRegWrite),
    .exMemRd       (exMemRd),
    .exMemResult   (exMemResult),
    .memWbRegWrite (memWbRegWrite),
    .memWbRd       (memWbRd),
    .memWbResult   (memWbResult),
    .fwdData       (fwdRs2)
  );

  // outValid is a direct decode of the state flop, so it stays registered.
  assign outValid = (state == ST_FULL);
  assign inReady  = !outValid || outReady;

  always_comb begin
    aSrc     = opA_src_t'(opASrc);
    bSrc     = opB_src_t'(opBSrc);
    capture  = inValid && inReady;
    transfer = outValid && outReady;
    nextA    = (aSrc == SRC_PC)  ? pcIn  : fwdRs1;
    nextB    = (bSrc == SRC_IMM) ? immIn : fwdRs2;
  end

  // Flush outranks capture; data registers are left as-is on flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_EMPTY;
      opA         <= '0;
      opB         <= '0;
      storeData   <= '0;
      aluOutSel   <= ALU_ADD;
      rdAddrOut   <= '0;
      regWriteOut <= 1'b0;
    end else if (flush) begin
      state       <= ST_EMPTY;
      regWriteOut <= 1'b0;
    end else if (capture) begin
      state       <= ST_FULL;
      opA         <= nextA;
      opB         <= nextB;
      storeData   <= fwdRs2;
      aluOutSel   <= aluSelIn;
      rdAddrOut   <= rdAddrIn;
      regWriteOut <= regWriteIn;
    end else if (transfer) begin
      state <= ST_EMPTY;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage with a per-cycle reference model.
module tb_alu_operand_stage;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned REG_AW = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              inValid;
  logic              inReady;
  logic [XLEN-1:0]   rs1Data, rs2Data, pcIn, immIn;
  logic [REG_AW-1:0] rs1Addr, rs2Addr, rdAddrIn;
  logic              opASrc, opBSrc, regWriteIn;
  logic [SEL_W-1:0]  aluSelIn;
  logic              exMemRegWrite, memWbRegWrite;
  logic [REG_AW-1:0] exMemRd, memWbRd;
  logic [XLEN-1:0]   exMemResult, memWbResult;
  logic              flush, outReady, outValid;
  logic [XLEN-1:0]   opA, opB, storeData;
  logic [SEL_W-1:0]  aluOutSel;
  logic [REG_AW-1:0] rdAddrOut;
  logic              regWriteOut;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_operand_stage #(
    .XLEN   (XLEN),
    .SEL_W  (SEL_W),
    .REG_AW (REG_AW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .inValid       (inValid),
    .inReady       (inReady),
    .rs1Data       (rs1Data),
    .rs2Data       (rs2Data),
    .rs1Addr       (rs1Addr),
    .rs2Addr       (rs2Addr),
    .pcIn          (pcIn),
    .immIn         (immIn),
    .opASrc        (opASrc),
    .opBSrc        (opBSrc),
    .aluSelIn      (aluSelIn),
    .rdAddrIn      (rdAddrIn),
    .regWriteIn    (regWriteIn),
    .exMemRegWrite (exMemRegWrite),
    .exMemRd       (exMemRd),
    .exMemResult   (exMemResult),
    .memWbRegWrite (memWbRegWrite),
    .memWbRd       (memWbRd),
    .memWbResult   (memWbResult),
    .flush         (flush),
    .outReady      (outReady),
    .outValid      (outValid),
    .opA           (opA),
    .opB           (opB),
    .aluOutSel     (aluOutSel),
    .storeData     (storeData),
    .rdAddrOut     (rdAddrOut),
    .regWriteOut   (regWriteOut)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Forwarded value of one source register, straight from the hazard rules.
  function automatic logic [XLEN-1:0] fwdVal(input logic [REG_AW-1:0] a, input logic [XLEN-1:0] d);
    if (a == 0) return d;
    if (exMemRegWrite && exMemRd == a) return exMemResult;
    if (memWbRegWrite && memWbRd == a) return memWbResult;
    return d;
  endfunction

  // Reference: a one-entry slot that is either occupied or not.
  logic              mValid;
  logic [XLEN-1:0]   mA, mB, mStore;
  logic [SEL_W-1:0]  mSel;
  logic [REG_AW-1:0] mRd;
  logic              mRw;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mValid <= 0; mA <= 0; mB <= 0; mStore <= 0; mSel <= 0; mRd <= 0; mRw <= 0;
    end else if (flush) begin
      mValid <= 0;
      mRw    <= 0;
    end else if (inValid && (!mValid || outReady)) begin
      mValid <= 1;
      mA     <= opASrc ? pcIn : fwdVal(rs1Addr, rs1Data);
      mB     <= opBSrc ? immIn : fwdVal(rs2Addr, rs2Data);
      mStore <= fwdVal(rs2Addr, rs2Data);
      mSel   <= aluSelIn;
      mRd    <= rdAddrIn;
      mRw    <= regWriteIn;
    end else if (mValid && outReady) begin
      mValid <= 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("outValid", 32'(outValid), 32'(mValid));
      chk("inReady", 32'(inReady), 32'(!mValid || outReady));
      if (mValid) begin
        chk("opA", opA, mA);
        chk("opB", opB, mB);
        chk("storeData", storeData, mStore);
        chk("aluOutSel", 32'(aluOutSel), 32'(mSel));
        chk("rdAddrOut", 32'(rdAddrOut), 32'(mRd));
        chk("regWriteOut", 32'(regWriteOut), 32'(mRw));
      end
    end
  end

  task automatic clearIn();
    inValid = 0; rs1Data = 0; rs2Data = 0; rs1Addr = 0; rs2Addr = 0;
    pcIn = 0; immIn = 0; opASrc = 0; opBSrc = 0; aluSelIn = 0;
    rdAddrIn = 0; regWriteIn = 0; exMemRegWrite = 0; exMemRd = 0;
    exMemResult = 0; memWbRegWrite = 0; memWbRd = 0; memWbResult = 0;
    flush = 0; outReady = 1;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    clearIn();
    rst_n = 0;
    #3;
    chk("rst_outValid", 32'(outValid), 32'h0);
    chk("rst_opA", opA, 32'h0);
    chk("rst_aluOutSel", 32'(aluOutSel), 32'h0);
    chk("rst_regWriteOut", 32'(regWriteOut), 32'h0);
    step(); step();
    rst_n = 1;
    step();

    // basic pass
    rs1Addr = 1; rs2Addr = 2; rs1Data = 5; rs2Data = 1; aluSelIn = 4'b0000;
    rdAddrIn = 7; regWriteIn = 1; inValid = 1;
    step();
    chk("basic_outValid", 32'(outValid), 32'h1);
    chk("basic_opA", opA, 32'h5);
    chk("basic_opB", opB, 32'h1);
    chk("basic_sel", 32'(aluOutSel), 32'h0);

    // forwarding priority, back-to-back captures
    rs1Addr = 3; rs1Data = 32'h11; rs2Addr = 9; rs2Data = 32'h44;
    exMemRegWrite = 1; exMemRd = 3; exMemResult = 32'h77;
    memWbRegWrite = 1; memWbRd = 3; memWbResult = 32'h22;
    step();
    chk("fwd_ex_opA", opA, 32'h77);
    chk("fwd_none_opB", opB, 32'h44);
    exMemRegWrite = 0;
    step();
    chk("fwd_wb_opA", opA, 32'h22);
    rs1Addr = 0; exMemRegWrite = 1; exMemRd = 0; memWbRd = 0;
    step();
    chk("fwd_x0_opA", opA, 32'h11);

    // operand select after forwarding
    clearIn();
    opASrc = 1; pcIn = 32'h100; opBSrc = 1; immIn = 32'hFFFF_FFFC;
    rs2Addr = 4; rs2Data = 32'h33; exMemRegWrite = 1; exMemRd = 4; exMemResult = 32'h9;
    aluSelIn = 4'b0001; inValid = 1;
    step();
    chk("sel_opA", opA, 32'h100);
    chk("sel_opB", opB, 32'hFFFF_FFFC);
    chk("sel_store", storeData, 32'h9);
    chk("sel_alu", 32'(aluOutSel), 32'h1);

    // stall with a pending instruction, then release with no bubble
    clearIn();
    rs1Addr = 1; rs1Data = 7; inValid = 1;
    step();
    chk("stall_load_opA", opA, 32'h7);
    outReady = 0; rs1Data = 1;
    #1;
    chk("stall_inReady", 32'(inReady), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_hold_opA", opA, 32'h7);
      chk("stall_hold_valid", 32'(outValid), 32'h1);
    end
    outReady = 1;
    step();
    chk("release_opA", opA, 32'h1);
    chk("release_valid", 32'(outValid), 32'h1);
    inValid = 0;
    step();
    chk("drain_valid", 32'(outValid), 32'h0);

    // flush beats capture and stall
    rs1Data = 32'h42; regWriteIn = 1; rdAddrIn = 5; inValid = 1;
    step();
    chk("preflush_rw", 32'(regWriteOut), 32'h1);
    flush = 1; outReady = 0; rs1Data = 32'h43;
    step();
    flush = 0; inValid = 0;
    #1;
    chk("flush_valid", 32'(outValid), 32'h0);
    chk("flush_rw", 32'(regWriteOut), 32'h0);
    chk("flush_inReady", 32'(inReady), 32'h1);
    outReady = 1;
    step();

    // short mixed run with varying readiness and hazards
    for (int i = 0; i < 40; i++) begin
      inValid = 1'($urandom_range(0, 1));
      outReady = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 9) == 0);
      rs1Addr = 5'($urandom_range(0, 3)); rs2Addr = 5'($urandom_range(0, 3));
      rs1Data = $urandom; rs2Data = $urandom; pcIn = $urandom; immIn = $urandom;
      opASrc = 1'($urandom_range(0, 1)); opBSrc = 1'($urandom_range(0, 1));
      aluSelIn = 4'($urandom_range(0, 9)); rdAddrIn = 5'($urandom);
      regWriteIn = 1'($urandom_range(0, 1));
      exMemRegWrite = 1'($urandom_range(0, 1)); exMemRd = 5'($urandom_range(0, 3));
      memWbRegWrite = 1'($urandom_range(0, 1)); memWbRd = 5'($urandom_range(0, 3));
      exMemResult = $urandom; memWbResult = $urandom;
      step();
    end

    // async reset between edges while holding a valid entry
    clearIn();
    rs1Addr = 1; rs1Data = 5; aluSelIn = 4'b0001; inValid = 1;
    step();
    chk("prerst_opA", opA, 32'h5);
    outReady = 0; inValid = 0;
    #1;
    rst_n = 0;
    #1;
    chk("midrst_valid", 32'(outValid), 32'h0);
    chk("midrst_opA", opA, 32'h0);
    chk("midrst_sel", 32'(aluOutSel), 32'h0);
    step();
    rst_n = 1;
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
